bk_mem_ctrl: RTL and testbench
==============================

BK_MEM_CTRL -- requirements
Module: bk_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 2*WIDTH: word width in bits; SHALL be a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 2**WIDTH: number of implemented words; legal range 1..2**WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port reqValid  input  1  request present.
REQ-007 SHALL have port reqReady  output  1  request accepted when reqValid and reqReady are both high on a rising edge.
REQ-008 SHALL have port reqWrite  input  1  1 = write, 0 = read.
REQ-009 SHALL have port reqAddr  input  WIDTH  word address.
REQ-010 SHALL have port reqData  input  DATA_WIDTH  write data.
REQ-011 SHALL have port reqByteEn  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-012 SHALL have port rspValid  output  1  read response present.
REQ-013 SHALL have port rspReady  input  1  consumer accepts the response.
REQ-014 SHALL have port rspData  output  DATA_WIDTH  read data.
REQ-015 SHALL have port rspErr  output  1  response addressed a word at or above DEPTH.
REQ-016 SHALL have port initDone  output  1  memory clear complete.

Function
REQ-017 SHALL implement a two-state FSM: INIT and RUN.
REQ-018 INIT SHALL write zero to one word per cycle, addresses 0 to DEPTH-1 ascending, then go to RUN; INIT lasts exactly DEPTH cycles.
REQ-019 initDone SHALL be 0 in INIT, 1 in RUN; reqReady SHALL be 0 in INIT.
REQ-020 In RUN, reqReady SHALL equal (!rspValid || rspReady), combinationally.
REQ-021 An accepted write with reqAddr < DEPTH SHALL update only the bytes whose reqByteEn bit is 1; the remaining bytes SHALL keep their values.
REQ-022 An accepted write SHALL generate no response.
REQ-023 An accepted write with reqAddr >= DEPTH SHALL change no storage and SHALL raise no error.
REQ-024 An accepted read SHALL assert rspValid on the following cycle with the registered word (one-cycle latency).
REQ-025 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-026 An accepted read with reqAddr >= DEPTH SHALL return rspData = 0 with rspErr = 1; in-range reads SHALL return rspErr = 0.
REQ-027 While rspValid is 1 and rspReady is 0, rspValid, rspData and rspErr SHALL hold stable, and no new request SHALL be accepted.
REQ-028 If rspValid and rspReady are both 1 and a read is accepted in the same cycle, the new response SHALL replace the old one with no bubble (full throughput: one read per cycle).
REQ-029 rspValid SHALL clear when rspValid and rspReady are both 1 and no read is accepted in that cycle.
REQ-030 reqWrite, reqAddr, reqData and reqByteEn SHALL be ignored when reqValid is 0 or reqReady is 0.

Reset
REQ-031 When rst_n is low, the block SHALL enter INIT with the sweep pointer = 0, rspValid = 0, rspData = 0, rspErr = 0 and initDone = 0.
REQ-032 A reset asserted in RUN or mid-INIT SHALL drop any pending response and restart the full clear sweep from address 0.

Verification
REQ-033 Release reset with DEPTH=256 -> initDone rises after exactly 256 cycles; reqReady is 0 throughout; a read of every address afterwards returns 0.
REQ-034 Write 0xBEEF to address 5 with byteEn=2'b11, then write 0x12xx to address 5 with byteEn=2'b10, then read address 5 -> rspData = 0x12EF one cycle after the read.
REQ-035 Issue back-to-back reads of addresses 1,2,3 with rspReady held 1 -> rspValid stays high for 3 consecutive cycles, data in order, no bubbles.
REQ-036 Read address 7 with rspReady held 0 for 4 cycles -> reqReady is 0 and the response is stable for 4 cycles; it completes on the first rspReady=1 edge.
REQ-037 With DEPTH=200, write 0xAAAA to address 250, then read address 250 -> rspData = 0 and rspErr = 1; address 199 is unchanged.
REQ-038 Pulse rst_n low midway through INIT and also in RUN while rspValid=1 -> rspValid goes to 0 immediately, and initDone returns after a full DEPTH cycles.

Source files
------------

// File: rtl/bk_mem_ctrl_if.sv
// Request/response bus for bk_mem_ctrl: a valid/ready request channel
// and a valid/ready read-response channel, plus the clear-complete flag.
interface bk_mem_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 2*WIDTH
);
  logic                    reqValid;
  logic                    reqReady;
  logic                    reqWrite;
  logic [WIDTH-1:0]        reqAddr;
  logic [DATA_WIDTH-1:0]   reqData;
  logic [DATA_WIDTH/8-1:0] reqByteEn;
  logic                    rspValid;
  logic                    rspReady;
  logic [DATA_WIDTH-1:0]   rspData;
  logic                    rspErr;
  logic                    initDone;

  modport master (
    output reqValid, reqWrite, reqAddr, reqData, reqByteEn, rspReady,
    input  reqReady, rspValid, rspData, rspErr, initDone
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, reqByteEn, rspReady,
    output reqReady, rspValid, rspData, rspErr, initDone
  );
endinterface

// File: rtl/bk_mem_ctrl.sv
// Single-port word memory with byte-enable writes, one-cycle registered reads,
// out-of-range error responses and a zero-clear sweep after every reset.
module bk_mem_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 2*WIDTH,
  parameter int DEPTH      = 2**WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  bk_mem_ctrl_if.slave bus
);
  localparam int NB = DATA_WIDTH/8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_reg;
  logic [WIDTH-1:0]      ptr_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic                  init_done_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic                  req_ready;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [NB-1:0]         we;
  logic [DATA_WIDTH-1:0] wdata;

  assign in_range  = {1'b0, bus.reqAddr} < (WIDTH+1)'(DEPTH);
  assign req_ready = init_done_reg && (!rsp_valid_reg || bus.rspReady);
  assign accept    = bus.reqValid && req_ready;
  assign rd_acc    = accept && !bus.reqWrite;
  assign wr_acc    = accept && bus.reqWrite && in_range;
  assign waddr     = (state_reg == INIT) ? ptr_reg[AW-1:0] : bus.reqAddr[AW-1:0];
  assign raddr     = bus.reqAddr[AW-1:0];

  // The clear sweep shares the write port: all lanes enabled, data forced to zero.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign we[gi]           = (state_reg == INIT) || (wr_acc && bus.reqByteEn[gi]);
      assign wdata[gi*8 +: 8] = (state_reg == INIT) ? 8'h00 : bus.reqData[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      ptr_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          ptr_reg <= ptr_reg + 1'b1;
          if (ptr_reg == WIDTH'(DEPTH-1)) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
            ptr_reg       <= '0;
          end
        end
        RUN: begin
          // A new read overwrites a response being consumed this same cycle.
          if (rd_acc) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= in_range ? mem[raddr] : '0;
            rsp_err_reg   <= !in_range;
          end else if (bus.rspReady) begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign bus.reqReady = req_ready;
  assign bus.rspValid = rsp_valid_reg;
  assign bus.rspData  = rsp_data_reg;
  assign bus.rspErr   = rsp_err_reg;
  assign bus.initDone = init_done_reg;
endmodule

// File: tb/tb_bk_mem_ctrl.sv
// Directed bench for bk_mem_ctrl: two instances (DEPTH 256 and 200) receive
// identical stimulus so the out-of-range behaviour can be compared side by side.
module tb_bk_mem_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bk_mem_ctrl_if #(.WIDTH(8), .DATA_WIDTH(16)) if0 ();
  bk_mem_ctrl_if #(.WIDTH(8), .DATA_WIDTH(16)) if1 ();

  bk_mem_ctrl #(.WIDTH(8), .DATA_WIDTH(16), .DEPTH(256)) dut  (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  bk_mem_ctrl #(.WIDTH(8), .DATA_WIDTH(16), .DEPTH(200)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    if0.reqValid = v; if0.reqWrite = w; if0.reqAddr = a; if0.reqData = d; if0.reqByteEn = be;
    if1.reqValid = v; if1.reqWrite = w; if1.reqAddr = a; if1.reqData = d; if1.reqByteEn = be;
  endtask

  task automatic set_rr(input logic r);
    if0.rspReady = r;
    if1.rspReady = r;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk); drive(1'b1, 1'b1, a, d, be);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk); drive(1'b1, 1'b0, a, 16'h0000, 2'b00);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
  endtask

  // Counts negedges until each instance reports initDone; -1 if the bound expires.
  task automatic wait_init(output int c0, output int c1, output bit rdy_seen);
    c0 = -1; c1 = -1; rdy_seen = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!if0.initDone && if0.reqReady) rdy_seen = 1'b1;
      if (!if1.initDone && if1.reqReady) rdy_seen = 1'b1;
      if (if0.initDone && c0 < 0) c0 = k;
      if (if1.initDone && c1 < 0) c1 = k;
      if (c0 >= 0 && c1 >= 0) break;
    end
  endtask

  task automatic test_reset();
    int c0, c1; bit rdy;
    @(negedge clk);
    checks++;
    if (if0.rspValid !== 1'b0 || if0.rspData !== 16'h0 || if0.rspErr !== 1'b0 ||
        if0.initDone !== 1'b0 || if0.reqReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h err=%b done=%b ready=%b, required all 0",
               if0.rspValid, if0.rspData, if0.rspErr, if0.initDone, if0.reqReady);
    end
    rst_n = 1'b1;
    wait_init(c0, c1, rdy);
    checks++;
    if (c0 !== 256) begin errors++; $display("FAIL init_len_256: got %0d cycles, required 256", c0); end
    checks++;
    if (c1 !== 200) begin errors++; $display("FAIL init_len_200: got %0d cycles, required 200", c1); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL ready_in_init: reqReady seen 1, required 0"); end
    $display("reset/init: init cycles dut=%0d dut2=%0d", c0, c1);
  endtask

  task automatic test_clear();
    int bad = 0;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (if0.rspValid !== 1'b1 || if0.rspData !== 16'h0 || if0.rspErr !== 1'b0) begin
          errors++; bad++;
          $display("FAIL clear_read addr %0d: valid=%b data=%h err=%b, required 1/0000/0",
                   i-1, if0.rspValid, if0.rspData, if0.rspErr);
        end
        checks++;
        if (if1.rspData !== 16'h0 || if1.rspErr !== ((i-1) >= 200)) begin
          errors++; bad++;
          $display("FAIL clear_read2 addr %0d: data=%h err=%b, required 0000/%b",
                   i-1, if1.rspData, if1.rspErr, ((i-1) >= 200));
        end
      end
      if (i < 256) drive(1'b1, 1'b0, 8'(i), 16'h0000, 2'b00);
      else         drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    end
    $display("clear sweep read: 256 addresses, %0d bad", bad);
  endtask

  task automatic test_byte_enable();
    wr(8'd5, 16'hBEEF, 2'b11);
    wr(8'd5, 16'h1234, 2'b10);
    rd(8'd5);
    checks++;
    if (if0.rspValid !== 1'b1 || if0.rspData !== 16'h12EF || if0.rspErr !== 1'b0) begin
      errors++;
      $display("FAIL byte_enable: valid=%b data=%h err=%b, required 1/12ef/0",
               if0.rspValid, if0.rspData, if0.rspErr);
    end
    $display("byte enable: read addr 5 -> %h", if0.rspData);
    @(negedge clk);
    checks++;
    if (if0.rspValid !== 1'b0) begin
      errors++; $display("FAIL rsp_clear: rspValid=%b, required 0", if0.rspValid);
    end
  endtask

  task automatic test_read_after_write();
    @(negedge clk); drive(1'b1, 1'b1, 8'd9, 16'h5A5A, 2'b11);
    @(negedge clk); drive(1'b1, 1'b0, 8'd9, 16'h0000, 2'b00);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    checks++;
    if (if0.rspValid !== 1'b1 || if0.rspData !== 16'h5A5A) begin
      errors++;
      $display("FAIL read_after_write: valid=%b data=%h, required 1/5a5a", if0.rspValid, if0.rspData);
    end
    $display("read after write: addr 9 -> %h", if0.rspData);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
    wr(8'd1, 16'h1111, 2'b11);
    wr(8'd2, 16'h2222, 2'b11);
    wr(8'd3, 16'h3333, 2'b11);
    @(negedge clk); drive(1'b1, 1'b0, 8'd1, 16'h0000, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (if0.rspValid !== 1'b1 || if0.rspData !== exp[k]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: valid=%b data=%h, required 1/%h", k, if0.rspValid, if0.rspData, exp[k]);
      end
      $display("back-to-back: response %0d data=%h", k, if0.rspData);
      if (k < 2) drive(1'b1, 1'b0, 8'(k+2), 16'h0000, 2'b00);
      else       drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    end
    @(negedge clk);
    checks++;
    if (if0.rspValid !== 1'b0) begin
      errors++; $display("FAIL back_to_back_end: rspValid=%b, required 0", if0.rspValid);
    end
  endtask

  task automatic test_stall();
    wr(8'd7, 16'h7777, 2'b11);
    @(negedge clk); set_rr(1'b0); drive(1'b1, 1'b0, 8'd7, 16'h0000, 2'b00);
    @(negedge clk); drive(1'b1, 1'b0, 8'd1, 16'h0000, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (if0.rspValid !== 1'b1 || if0.rspData !== 16'h7777 || if0.rspErr !== 1'b0 || if0.reqReady !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b data=%h err=%b ready=%b, required 1/7777/0/0",
                 k, if0.rspValid, if0.rspData, if0.rspErr, if0.reqReady);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    set_rr(1'b1);
    @(negedge clk);
    checks++;
    if (if0.rspValid !== 1'b0) begin
      errors++; $display("FAIL stall_release: rspValid=%b, required 0", if0.rspValid);
    end
    $display("stall: response held 4 cycles, released on rspReady");
  endtask

  task automatic test_out_of_range();
    wr(8'd199, 16'h1990, 2'b11);
    wr(8'd250, 16'hAAAA, 2'b11);
    rd(8'd250);
    checks++;
    if (if1.rspValid !== 1'b1 || if1.rspData !== 16'h0 || if1.rspErr !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: valid=%b data=%h err=%b, required 1/0000/1", if1.rspValid, if1.rspData, if1.rspErr);
    end
    checks++;
    if (if0.rspData !== 16'hAAAA || if0.rspErr !== 1'b0) begin
      errors++;
      $display("FAIL inrange_250: data=%h err=%b, required aaaa/0", if0.rspData, if0.rspErr);
    end
    rd(8'd199);
    checks++;
    if (if1.rspData !== 16'h1990 || if1.rspErr !== 1'b0) begin
      errors++;
      $display("FAIL addr199_kept: data=%h err=%b, required 1990/0", if1.rspData, if1.rspErr);
    end
    $display("out of range: dut2 addr 250 err=%b, addr 199=%h", 1'b1, if1.rspData);
  endtask

  task automatic test_reset_midway();
    int c0, c1; bit rdy;
    set_rr(1'b0);
    rd(8'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if0.rspValid !== 1'b0 || if0.rspData !== 16'h0 || if0.initDone !== 1'b0 || if0.reqReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_run: valid=%b data=%h done=%b ready=%b, required 0/0000/0/0",
               if0.rspValid, if0.rspData, if0.initDone, if0.reqReady);
    end
    set_rr(1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if0.initDone !== 1'b0 || if0.rspValid !== 1'b0) begin
      errors++; $display("FAIL reset_in_init: done=%b valid=%b, required 0/0", if0.initDone, if0.rspValid);
    end
    #1 rst_n = 1'b1;
    wait_init(c0, c1, rdy);
    checks++;
    if (c0 !== 256 || c1 !== 200 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL reinit_len: dut=%0d dut2=%0d ready_seen=%b, required 256/200/0", c0, c1, rdy);
    end
    rd(8'd5);
    checks++;
    if (if0.rspValid !== 1'b1 || if0.rspData !== 16'h0) begin
      errors++; $display("FAIL recleared: valid=%b data=%h, required 1/0000", if0.rspValid, if0.rspData);
    end
    rd(8'd199);
    checks++;
    if (if1.rspData !== 16'h0 || if1.rspErr !== 1'b0) begin
      errors++; $display("FAIL recleared2: data=%h err=%b, required 0000/0", if1.rspData, if1.rspErr);
    end
    $display("reset midway: re-init cycles dut=%0d dut2=%0d", c0, c1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    set_rr(1'b1);
    test_reset();
    test_clear();
    test_byte_enable();
    test_read_after_write();
    test_back_to_back();
    test_stall();
    test_out_of_range();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
